// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU state type and
// the byte-enable / store-replication / misalignment helpers.
package riscv_pkg;

  localparam logic [2:0] LB_F3  = 3'd0;
  localparam logic [2:0] LH_F3  = 3'd1;
  localparam logic [2:0] LW_F3  = 3'd2;
  localparam logic [2:0] LBU_F3 = 3'd4;
  localparam logic [2:0] LHU_F3 = 3'd5;
  localparam logic [2:0] SB_F3  = 3'd0;
  localparam logic [2:0] SH_F3  = 3'd1;
  localparam logic [2:0] SW_F3  = 3'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

  // Unsupported encodings (3, 6, 7) fall through to a word access.
  function automatic acc_size_t f3_size(input logic [2:0] f3);
    case (f3)
      LB_F3, LBU_F3: return SZ_BYTE;
      LH_F3, LHU_F3: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3_size(f3))
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_replicate(input logic [2:0] f3, input logic [31:0] d);
    case (f3_size(f3))
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3_size(f3))
      SZ_HALF: return a[0];
      SZ_WORD: return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the byte/half lane of a read word by address and sign/zero-extends
// it according to funct3; words pass through untouched.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr, 3'b000} +: 8];
  assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: every path assigns result (default arm included), so no latch is inferred.
  always_comb begin
    case (funct3)
      LB_F3:   result = {{24{byte_lane[7]}}, byte_lane};
      LBU_F3:  result = {24'h0, byte_lane};
      LH_F3:   result = {{16{half_lane[15]}}, half_lane};
      LHU_F3:  result = {16'h0, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between execute and data memory.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses complete without a memory request.
module lsu
  import riscv_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 32,
  parameter int F3_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_is_store,
  input  logic [F3_WIDTH-1:0] i_funct3,
  input  logic [AWIDTH-1:0]   i_addr,
  input  logic [DWIDTH-1:0]   i_wdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [AWIDTH-1:0]   o_mem_addr,
  output logic [3:0]          o_mem_be,
  output logic [DWIDTH-1:0]   o_mem_wdata,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DWIDTH-1:0]   i_mem_rdata,
  output logic                o_done,
  output logic [DWIDTH-1:0]   o_rdata,
  output logic                o_misaligned
);

  lsu_state_t          state, state_n;
  logic                store_q;
  logic [F3_WIDTH-1:0] f3_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [DWIDTH-1:0]   rdata_q;
  logic [DWIDTH-1:0]   load_res;
  logic                accept;

  assign accept = i_valid && (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  logic mis_in;
  assign mis_in = is_misaligned(i_funct3, i_addr[1:0]);
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
        state_n = mis_in ? DONE : REQ;
`else
        state_n = REQ;
`endif
      end
      REQ:  if (i_mem_gnt) state_n = store_q ? DONE : WAIT;
      WAIT: if (i_mem_rvalid) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Memory-side outputs are only non-zero while the request is presented.
  always_comb begin
    o_ready      = (state == IDLE);
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_be     = 4'b0000;
    o_mem_wdata  = '0;
    o_done       = 1'b0;
    o_misaligned = 1'b0;
    case (state)
      REQ: begin
        o_mem_req   = 1'b1;
        o_mem_we    = store_q;
        o_mem_addr  = {addr_q[AWIDTH-1:2], 2'b00};
        o_mem_be    = byte_en(f3_q, addr_q[1:0]);
        o_mem_wdata = store_replicate(f3_q, wdata_q);
      end
      DONE: begin
        o_done = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        o_misaligned = mis_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        store_q <= i_is_store;
        f3_q    <= i_funct3;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_q   <= mis_in;
`endif
      end
      if (state == WAIT && i_mem_rvalid) rdata_q <= load_res;
    end
  end

  assign o_rdata = rdata_q;

  load_align u_load_align (
    .rdata  (i_mem_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .result (load_res)
  );

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; a small responder grants/returns data
// after programmable delays and records what the LSU presented.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        o_ready;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_misaligned;

  int total = 0;
  int bad   = 0;

  // Observations of the last access
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_we, m_mis;
  int          done_cyc, done_w, req_cnt;
  bit          stable, ready_ok;

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_is_store   (i_is_store),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_be     (o_mem_be),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_misaligned (o_misaligned)
  );

  // Accept one access, then act as memory: grant after gd REQ cycles, return
  // data after rd WAIT cycles. Cycle numbering: accept cycle is 0.
  task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int gd, input int rd,
                            input logic [31:0] rdat);
    int  wc;
    bit  granted, rv_sent, seen_done;
    m_addr = '0; m_wdata = '0; m_be = '0; m_we = 1'b0; m_mis = 1'b0;
    done_cyc = -1; done_w = 0; req_cnt = 0; stable = 1'b1; ready_ok = 1'b1;
    wc = 0; granted = 1'b0; rv_sent = 1'b0; seen_done = 1'b0;
    @(negedge clk);
    i_valid = 1'b1; i_is_store = st; i_funct3 = f3; i_addr = a; i_wdata = wd;
    @(posedge clk);
    #1 i_valid = 1'b0;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(negedge clk);
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
      if (o_mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          m_addr = o_mem_addr; m_be = o_mem_be; m_wdata = o_mem_wdata; m_we = o_mem_we;
        end else if (o_mem_addr !== m_addr || o_mem_be !== m_be ||
                     o_mem_wdata !== m_wdata || o_mem_we !== m_we) begin
          stable = 1'b0;
        end
        if (req_cnt > gd) begin i_mem_gnt = 1'b1; granted = 1'b1; end
      end else if (granted && !st && !rv_sent) begin
        wc++;
        if (wc > rd) begin i_mem_rvalid = 1'b1; i_mem_rdata = rdat; rv_sent = 1'b1; end
      end
      if (o_done) begin
        if (!seen_done) begin done_cyc = cyc; m_mis = o_misaligned; seen_done = 1'b1; end
        done_w++;
      end else if (seen_done) begin
        if (!o_ready) ready_ok = 1'b0;
        break;
      end else if (o_ready) begin
        ready_ok = 1'b0;
      end
    end
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_valid = 1'b0; i_is_store = 1'b0; i_funct3 = '0; i_addr = '0;
    i_wdata = '0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    total++; if (o_mem_req !== 1'b0 || o_done !== 1'b0 || o_misaligned !== 1'b0)
      begin bad++; $display("FAIL reset_ctrl req=%b done=%b mis=%b exp=0", o_mem_req, o_done, o_misaligned); end
    total++; if (o_rdata !== 32'h0 || o_mem_be !== 4'h0)
      begin bad++; $display("FAIL reset_data rdata=%h be=%b exp=0", o_rdata, o_mem_be); end
    reset = 1'b0;
  endtask

  task automatic test_store();
    run_access(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0);
    total++; if (m_addr !== 32'h104 || m_be !== 4'b1111 || m_we !== 1'b1 || m_wdata !== 32'hDEADBEEF)
      begin bad++; $display("FAIL sw_bus addr=%h be=%b we=%b wdata=%h exp 104/1111/1/deadbeef", m_addr, m_be, m_we, m_wdata); end
    total++; if (done_cyc !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", done_cyc); end
    run_access(1'b1, 3'd0, 32'h203, 32'h000000A5, 0, 0, 32'h0);
    total++; if (m_addr !== 32'h200 || m_be !== 4'b1000 || m_wdata !== 32'hA5A5A5A5)
      begin bad++; $display("FAIL sb_bus addr=%h be=%b wdata=%h exp 200/1000/a5a5a5a5", m_addr, m_be, m_wdata); end
    run_access(1'b1, 3'd1, 32'h302, 32'h1234BEEF, 1, 0, 32'h0);
    total++; if (m_addr !== 32'h300 || m_be !== 4'b1100 || m_wdata !== 32'hBEEFBEEF)
      begin bad++; $display("FAIL sh_bus addr=%h be=%b wdata=%h exp 300/1100/beefbeef", m_addr, m_be, m_wdata); end
    total++; if (done_cyc !== 3 || !stable) begin bad++; $display("FAIL sh_gnt_wait done=%0d stable=%b exp 3/1", done_cyc, stable); end
  endtask

  task automatic test_load_extend();
    run_access(1'b0, 3'd0, 32'h101, 32'h0, 0, 0, 32'h123480FF);
    total++; if (o_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=ffffff80", o_rdata); end
    total++; if (m_be !== 4'b0010 || m_we !== 1'b0 || m_addr !== 32'h100)
      begin bad++; $display("FAIL lb_bus be=%b we=%b addr=%h exp 0010/0/100", m_be, m_we, m_addr); end
    total++; if (done_cyc !== 3) begin bad++; $display("FAIL lb_latency got=%0d exp=3", done_cyc); end
    run_access(1'b0, 3'd4, 32'h101, 32'h0, 0, 0, 32'h123480FF);
    total++; if (o_rdata !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", o_rdata); end
    run_access(1'b0, 3'd5, 32'h102, 32'h0, 0, 0, 32'h123480FF);
    total++; if (o_rdata !== 32'h00001234) begin bad++; $display("FAIL lhu got=%h exp=00001234", o_rdata); end
    run_access(1'b0, 3'd1, 32'h102, 32'h0, 0, 0, 32'h80010000);
    total++; if (o_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh got=%h exp=ffff8001", o_rdata); end
    run_access(1'b0, 3'd3, 32'h100, 32'h0, 0, 0, 32'h87654321);
    total++; if (o_rdata !== 32'h87654321 || m_be !== 4'b1111)
      begin bad++; $display("FAIL f3_unsupported got=%h be=%b exp 87654321/1111", o_rdata, m_be); end
  endtask

  task automatic test_delayed_load();
    run_access(1'b0, 3'd2, 32'h400, 32'h0, 3, 2, 32'hCAFEF00D);
    total++; if (req_cnt !== 4 || !stable) begin bad++; $display("FAIL lw_req_hold cycles=%0d stable=%b exp 4/1", req_cnt, stable); end
    total++; if (done_cyc !== 8) begin bad++; $display("FAIL lw_latency got=%0d exp=8", done_cyc); end
    total++; if (done_w !== 1) begin bad++; $display("FAIL lw_done_width got=%0d exp=1", done_w); end
    total++; if (!ready_ok) begin bad++; $display("FAIL lw_ready got=bad exp=low until after done"); end
    total++; if (o_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL lw_data got=%h exp=cafef00d", o_rdata); end
  endtask

  task automatic test_back_to_back();
    // A store right after a load must not disturb the held load result.
    run_access(1'b0, 3'd0, 32'h503, 32'h0, 0, 0, 32'h7F000000);
    run_access(1'b1, 3'd2, 32'h600, 32'h11223344, 0, 0, 32'hFFFFFFFF);
    total++; if (o_rdata !== 32'h0000007F) begin bad++; $display("FAIL rdata_hold got=%h exp=0000007f", o_rdata); end
  endtask

  task automatic test_reset_mid_access();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    i_valid = 1'b1; i_is_store = 1'b0; i_funct3 = 3'd2; i_addr = 32'h700;
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    i_mem_gnt = 1'b1;
    @(negedge clk);
    i_mem_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h55555555;
    total++; if (o_ready !== 1'b1 || o_mem_req !== 1'b0)
      begin bad++; $display("FAIL rst_wait_idle ready=%b req=%b exp 1/0", o_ready, o_mem_req); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_mem_rvalid = 1'b0;
      if (o_done) saw_done = 1'b1;
    end
    total++; if (saw_done || o_ready !== 1'b1 || o_rdata !== 32'h0)
      begin bad++; $display("FAIL rst_late_rvalid done=%b ready=%b rdata=%h exp 0/1/0", saw_done, o_ready, o_rdata); end
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 3'd2, 32'h102, 32'h0, 0, 0, 32'h89ABCDEF);
`ifdef LSU_MISALIGN_TRAP_EN
    total++; if (req_cnt !== 0) begin bad++; $display("FAIL mis_no_req got=%0d exp=0", req_cnt); end
    total++; if (done_cyc !== 1 || m_mis !== 1'b1)
      begin bad++; $display("FAIL mis_trap done=%0d mis=%b exp 1/1", done_cyc, m_mis); end
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL mis_rdata got=%h exp=0", o_rdata); end
`else
    total++; if (m_addr !== 32'h100 || m_be !== 4'b1111)
      begin bad++; $display("FAIL mis_aligned_down addr=%h be=%b exp 100/1111", m_addr, m_be); end
    total++; if (done_cyc !== 3 || m_mis !== 1'b0 || o_rdata !== 32'h89ABCDEF)
      begin bad++; $display("FAIL mis_normal done=%0d mis=%b rdata=%h exp 3/0/89abcdef", done_cyc, m_mis, o_rdata); end
`endif
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_extend();
    test_delayed_load();
    test_back_to_back();
    test_reset_mid_access();
    test_misaligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
